wb_select_reg: RTL

- Parametrised write-back data register for the multicycle CPU datapath.
- Selects one of NSRC 32-bit result sources and performs load alignment with sign/zero extension for the memory source.
- Waits on a memory-valid handshake when load data arrives late, then registers the result for the register-file write.
- Sits between ALU/data-memory outputs and the register-file write port; the ALU-vs-memory write-back register generalises to this block.

---
 rtl/wb_select_reg.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_select_reg.sv
// Write-back data register: selects a result source, aligns/extends memory loads,
// waits for late load data with a bounded timeout, and registers the regfile write value.
module wb_select_reg #(
  parameter int NSRC    = 4,
  parameter int SELW    = 2,
  parameter int MEM_SRC = 1,
  parameter int TIMEOUT = 15
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_flush,
  input  logic [SELW-1:0]     i_src_sel,
  input  logic [NSRC*32-1:0]  i_srcs,
  input  logic [2:0]          i_ld_type,
  input  logic [1:0]          i_addr_lo,
  input  logic                i_mem_valid,
  output logic [31:0]         o_wb_data,
  output logic                o_wb_valid,
  output logic                o_busy,
  output logic                o_misalign,
  output logic                o_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [2:0]    r_ldType;
  logic [1:0]    r_addrLo;
  logic [31:0]   r_wbData;
  logic          r_wbValid;
  logic          r_misalign;
  logic          r_timeout;

  state_t        w_nextState;
  logic [CW-1:0] w_nextCount;
  logic [31:0]   w_nextData;
  logic          w_nextValid;
  logic          w_nextMisalign;
  logic          w_nextTimeout;
  logic          w_latchLoad;

  logic [31:0]   w_selData;
  logic [31:0]   w_memData;
  logic          w_isMem;
  logic [2:0]    w_ldType;
  logic [1:0]    w_addrLo;
  logic [31:0]   w_aligned;
  logic          w_misaligned;
  logic [15:0]   w_half;
  logic [7:0]    w_byte;

  // Out-of-range selects fall back to source 0, so its data is the default.
  always_comb begin
    w_selData = i_srcs[31:0];
    w_isMem   = (MEM_SRC == 0);
    for (int i = 1; i < NSRC; i++) begin
      if (int'(i_src_sel) == i) begin
        w_selData = i_srcs[32*i +: 32];
        w_isMem   = (i == MEM_SRC);
      end
    end
  end

  assign w_memData = i_srcs[32*MEM_SRC +: 32];

  // A load that arrived late must use the type/offset captured when it was issued.
  assign w_ldType = (r_state == WAIT_MEM) ? r_ldType : i_ld_type;
  assign w_addrLo = (r_state == WAIT_MEM) ? r_addrLo : i_addr_lo;

  assign w_half = w_addrLo[1] ? w_memData[31:16] : w_memData[15:0];

  always_comb begin
    w_byte = w_memData[7:0];
    case (w_addrLo)
      2'd1:    w_byte = w_memData[15:8];
      2'd2:    w_byte = w_memData[23:16];
      2'd3:    w_byte = w_memData[31:24];
      default: w_byte = w_memData[7:0];
    endcase
  end

  always_comb begin
    w_aligned    = w_memData;
    w_misaligned = 1'b0;
    case (w_ldType)
      3'd1: begin
        w_misaligned = w_addrLo[0];
        w_aligned    = {{16{w_half[15]}}, w_half};
      end
      3'd2: begin
        w_misaligned = w_addrLo[0];
        w_aligned    = {16'h0000, w_half};
      end
      3'd3: w_aligned = {{24{w_byte[7]}}, w_byte};
      3'd4: w_aligned = {24'h000000, w_byte};
      default: begin
        w_misaligned = (w_addrLo != 2'd0);
        w_aligned    = w_memData;
      end
    endcase
  end

  always_comb begin
    w_nextState    = r_state;
    w_nextCount    = r_count;
    w_nextData     = r_wbData;
    w_nextValid    = 1'b0;
    w_nextMisalign = 1'b0;
    w_nextTimeout  = 1'b0;
    w_latchLoad    = 1'b0;
    if (i_flush) begin
      w_nextState = IDLE;
      w_nextCount = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_en) begin
            if (!w_isMem) begin
              w_nextData  = w_selData;
              w_nextValid = 1'b1;
            end else if (i_mem_valid) begin
              if (w_misaligned) begin
                w_nextMisalign = 1'b1;
              end else begin
                w_nextData  = w_aligned;
                w_nextValid = 1'b1;
              end
            end else begin
              w_nextState = WAIT_MEM;
              w_nextCount = '0;
              w_latchLoad = 1'b1;
            end
          end
        end
        WAIT_MEM: begin
          // Data arriving on the final allowed cycle still beats the timeout.
          if (i_mem_valid) begin
            w_nextState = IDLE;
            w_nextCount = '0;
            if (w_misaligned) begin
              w_nextMisalign = 1'b1;
            end else begin
              w_nextData  = w_aligned;
              w_nextValid = 1'b1;
            end
          end else if (r_count == LAST_CNT) begin
            w_nextState   = IDLE;
            w_nextCount   = '0;
            w_nextTimeout = 1'b1;
          end else begin
            w_nextCount = r_count + CW'(1);
          end
        end
        default: begin
          w_nextState = IDLE;
          w_nextCount = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_ldType   <= 3'd0;
      r_addrLo   <= 2'd0;
      r_wbData   <= 32'h0;
      r_wbValid  <= 1'b0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_count    <= w_nextCount;
      r_wbData   <= w_nextData;
      r_wbValid  <= w_nextValid;
      r_misalign <= w_nextMisalign;
      r_timeout  <= w_nextTimeout;
      if (w_latchLoad) begin
        r_ldType <= i_ld_type;
        r_addrLo <= i_addr_lo;
      end
    end
  end

  assign o_wb_data  = r_wbData;
  assign o_wb_valid = r_wbValid;
  assign o_busy     = (r_state == WAIT_MEM);
  assign o_misalign = r_misalign;
  assign o_timeout  = r_timeout;

endmodule
